// File: rtl/ex_stage_pkg.sv
// Shared opcode/funct encodings, FSM state codes and the EX/MEM field bundle.
// Constants only; no latency or backpressure of its own.
package ex_stage_pkg;

    localparam logic [5:0] OP_R    = 6'd0;
    localparam logic [5:0] OP_ADDI = 6'd1;
    localparam logic [5:0] OP_ANDI = 6'd4;
    localparam logic [5:0] OP_ORI  = 6'd5;
    localparam logic [5:0] OP_LW   = 6'd16;
    localparam logic [5:0] OP_SW   = 6'd24;
    localparam logic [5:0] OP_BEQ  = 6'd32;
    localparam logic [5:0] OP_NOP  = 6'b110111;

    localparam logic [5:0] F_SLL   = 6'd0;
    localparam logic [5:0] F_SRL   = 6'd2;
    localparam logic [5:0] F_MFHI  = 6'd16;
    localparam logic [5:0] F_MFLO  = 6'd18;
    localparam logic [5:0] F_MULT  = 6'd24;
    localparam logic [5:0] F_MULTU = 6'd25;
    localparam logic [5:0] F_DIV   = 6'd26;
    localparam logic [5:0] F_DIVU  = 6'd27;
    localparam logic [5:0] F_ADD   = 6'd32;
    localparam logic [5:0] F_SUB   = 6'd34;
    localparam logic [5:0] F_AND   = 6'd36;
    localparam logic [5:0] F_OR    = 6'd37;
    localparam logic [5:0] F_SLT   = 6'd42;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef struct packed {
        logic [5:0]  op;
        logic [4:0]  wreg;
        logic [31:0] result;
        logic [31:0] sdata;
        logic        br_taken;
        logic [31:0] br_target;
    } em_t;

    localparam em_t EM_NOP = '{op: OP_NOP, wreg: 5'd0, result: 32'd0,
                               sdata: 32'd0, br_taken: 1'b0, br_target: 32'd0};

    // funct 24..27 share the 0110xx pattern
    function automatic logic is_muldiv(input logic [5:0] op, input logic [5:0] funct);
        return (op == OP_R) && (funct[5:2] == 4'b0110);
    endfunction

endpackage

// File: rtl/ex_stage_muldiv.sv
// Iterative 32-step mult/multu/div/divu with HI/LO; 33 stall cycles then a DONE cycle.
// Backpressure: stall_o holds the upstream register from the start cycle through BUSY.
module muldiv_unit
    import ex_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rstd,
    input  logic        start_i,
    input  logic [5:0]  funct_i,
    input  logic [31:0] os_i,
    input  logic [31:0] ot_i,
    output logic        stall_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    logic [1:0]  state_q, state_d;
    logic [5:0]  count_q, count_d;
    logic [63:0] p_q, p_d;
    logic [31:0] b_q, b_d;
    logic        mul_q, mul_d;
    logic        neg_q, neg_d;
    logic        negr_q, negr_d;
    logic        divz_q, divz_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;

    logic        signed_op, a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [32:0] mul_sum, r_sh, r_sub;
    logic [63:0] mul_p, div_p, prod;
    logic [31:0] quo_f, rem_f;

    assign stall_o = ((state_q == ST_IDLE) && start_i) || (state_q == ST_BUSY);
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;

    // even functs (24, 26) are the signed forms
    assign signed_op = ~funct_i[0];
    assign a_neg     = signed_op & os_i[31];
    assign b_neg     = signed_op & ot_i[31];
    assign a_mag     = a_neg ? -os_i : os_i;
    assign b_mag     = b_neg ? -ot_i : ot_i;

    assign mul_sum = {1'b0, p_q[63:32]} + (p_q[0] ? {1'b0, b_q} : 33'd0);
    assign mul_p   = {mul_sum, p_q[31:1]};

    // restoring step: {remainder, dividend/quotient} shifts left one bit per cycle
    assign r_sh  = {p_q[63:32], p_q[31]};
    assign r_sub = r_sh - {1'b0, b_q};
    assign div_p = r_sub[32] ? {r_sh[31:0], p_q[30:0], 1'b0}
                             : {r_sub[31:0], p_q[30:0], 1'b1};

    assign prod  = neg_q ? -p_q : p_q;
    assign quo_f = divz_q ? 32'hFFFF_FFFF : (neg_q ? -p_q[31:0] : p_q[31:0]);
    assign rem_f = negr_q ? -p_q[63:32] : p_q[63:32];

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        p_d     = p_q;
        b_d     = b_q;
        mul_d   = mul_q;
        neg_d   = neg_q;
        negr_d  = negr_q;
        divz_d  = divz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    p_d     = {32'd0, a_mag};
                    b_d     = b_mag;
                    mul_d   = ~funct_i[1];
                    neg_d   = a_neg ^ b_neg;
                    negr_d  = a_neg;
                    divz_d  = (ot_i == 32'd0);
                    count_d = 6'd32;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                p_d     = mul_q ? mul_p : div_p;
                count_d = count_q - 6'd1;
                if (count_q == 6'd1) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                hi_d    = mul_q ? prod[63:32] : rem_f;
                lo_d    = mul_q ? prod[31:0]  : quo_f;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            state_q <= ST_IDLE;
            count_q <= 6'd0;
            p_q     <= 64'd0;
            b_q     <= 32'd0;
            mul_q   <= 1'b0;
            neg_q   <= 1'b0;
            negr_q  <= 1'b0;
            divz_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            p_q     <= p_d;
            b_q     <= b_d;
            mul_q   <= mul_d;
            neg_q   <= neg_d;
            negr_q  <= negr_d;
            divz_q  <= divz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU/branch into the EX/MEM register (latency 1), plus mul/div.
// Backpressure: stall is combinational from muldiv_unit; EX/MEM takes a NOP while it is high.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rstd,
    input  logic [31:0] pc_in,
    input  logic [5:0]  op_in,
    input  logic [4:0]  rt_in,
    input  logic [4:0]  rd_in,
    input  logic [10:0] aux_in,
    input  logic [31:0] imm_dpl_in,
    input  logic [31:0] os_in,
    input  logic [31:0] ot_in,
    output logic        stall,
    output logic [5:0]  em_op,
    output logic [4:0]  em_wreg,
    output logic [31:0] em_result,
    output logic [31:0] em_sdata,
    output logic        br_taken,
    output logic [31:0] br_target
);

    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] zimm, hi, lo;
    logic        md_start, vld;
    em_t         em_q, em_d, alu;

    assign funct    = aux_in[5:0];
    assign shamt    = aux_in[10:6];
    assign zimm     = {16'd0, imm_dpl_in[15:0]};
    assign md_start = is_muldiv(op_in, funct);

    muldiv_unit u_muldiv (
        .clk     (clk),
        .rstd    (rstd),
        .start_i (md_start),
        .funct_i (funct),
        .os_i    (os_in),
        .ot_i    (ot_in),
        .stall_o (stall),
        .hi_o    (hi),
        .lo_o    (lo)
    );

    always_comb begin
        alu    = EM_NOP;
        vld    = 1'b1;
        alu.op = op_in;
        case (op_in)
            OP_R: begin
                alu.wreg = rd_in;
                case (funct)
                    F_ADD:  alu.result = os_in + ot_in;
                    F_SUB:  alu.result = os_in - ot_in;
                    F_AND:  alu.result = os_in & ot_in;
                    F_OR:   alu.result = os_in | ot_in;
                    F_SLT:  alu.result = {31'd0, $signed(os_in) < $signed(ot_in)};
                    F_SLL:  alu.result = ot_in << shamt;
                    F_SRL:  alu.result = ot_in >> shamt;
                    F_MFHI: alu.result = hi;
                    F_MFLO: alu.result = lo;
                    default: vld = 1'b0;
                endcase
            end
            OP_ADDI: begin
                alu.wreg   = rt_in;
                alu.result = os_in + imm_dpl_in;
            end
            OP_ANDI: begin
                alu.wreg   = rt_in;
                alu.result = os_in & zimm;
            end
            OP_ORI: begin
                alu.wreg   = rt_in;
                alu.result = os_in | zimm;
            end
            OP_LW: begin
                alu.wreg   = rt_in;
                alu.result = os_in + imm_dpl_in;
                alu.sdata  = ot_in;
            end
            OP_SW: begin
                alu.result = os_in + imm_dpl_in;
                alu.sdata  = ot_in;
            end
            OP_BEQ: begin
                alu.br_taken  = (os_in == ot_in);
                alu.br_target = pc_in + imm_dpl_in;
            end
            default: vld = 1'b0;
        endcase
    end

    // mul/div functs fall into the unknown-funct path, so their DONE cycle also sends a NOP
    assign em_d = (vld && !stall) ? alu : EM_NOP;

    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            em_q <= EM_NOP;
        end else begin
            em_q <= em_d;
        end
    end

    assign em_op     = em_q.op;
    assign em_wreg   = em_q.wreg;
    assign em_result = em_q.result;
    assign em_sdata  = em_q.sdata;
    assign br_taken  = em_q.br_taken;
    assign br_target = em_q.br_target;

endmodule

// File: tb/tb_ex_stage.sv
// Directed-vector bench for ex_stage: ALU ops, branches, mul/div sequences and reset abort.
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rstd = 1'b0;
    logic [31:0] pc_in = 32'h100;
    logic [5:0]  op_in = OP_NOP;
    logic [4:0]  rt_in = 5'd3;
    logic [4:0]  rd_in = 5'd9;
    logic [10:0] aux_in = 11'd0;
    logic [31:0] imm_dpl_in = 32'd0;
    logic [31:0] os_in = 32'd0;
    logic [31:0] ot_in = 32'd0;
    logic        stall;
    logic [5:0]  em_op;
    logic [4:0]  em_wreg;
    logic [31:0] em_result, em_sdata, br_target;
    logic        br_taken;

    int errors = 0;
    int checks = 0;

    ex_stage dut (
        .clk        (clk),
        .rstd       (rstd),
        .pc_in      (pc_in),
        .op_in      (op_in),
        .rt_in      (rt_in),
        .rd_in      (rd_in),
        .aux_in     (aux_in),
        .imm_dpl_in (imm_dpl_in),
        .os_in      (os_in),
        .ot_in      (ot_in),
        .stall      (stall),
        .em_op      (em_op),
        .em_wreg    (em_wreg),
        .em_result  (em_result),
        .em_sdata   (em_sdata),
        .br_taken   (br_taken),
        .br_target  (br_target)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic [5:0] op, input logic [10:0] aux,
                          input logic [31:0] os, input logic [31:0] ot, input logic [31:0] imm);
        op_in = op; aux_in = aux; os_in = os; ot_in = ot; imm_dpl_in = imm;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_op"},     {26'd0, em_op}, {26'd0, OP_NOP});
        chk({tag, "_wreg"},   {27'd0, em_wreg}, 32'd0);
        chk({tag, "_result"}, em_result, 32'd0);
        chk({tag, "_sdata"},  em_sdata, 32'd0);
        chk({tag, "_brt"},    {31'd0, br_taken}, 32'd0);
        chk({tag, "_brtgt"},  br_target, 32'd0);
        chk({tag, "_stall"},  {31'd0, stall}, 32'd0);
    endtask

    // present one single-cycle op, check stall is low, then check EX/MEM after the edge
    task automatic alu(input string tag, input logic [5:0] op, input logic [10:0] aux,
                       input logic [31:0] os, input logic [31:0] ot, input logic [31:0] imm,
                       input logic [5:0] exp_op, input logic [31:0] exp_res, input logic [4:0] exp_wreg);
        set_in(op, aux, os, ot, imm);
        #1;
        chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        chk({tag, "_op"},     {26'd0, em_op}, {26'd0, exp_op});
        chk({tag, "_result"}, em_result, exp_res);
        chk({tag, "_wreg"},   {27'd0, em_wreg}, {27'd0, exp_wreg});
    endtask

    task automatic run_md(input string tag, input logic [5:0] f, input logic [31:0] os,
                          input logic [31:0] ot, input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        int n;
        n = 0;
        set_in(OP_R, {5'd0, f}, os, ot, 32'd0);
        #1;
        chk({tag, "_stall0"}, {31'd0, stall}, 32'd1);
        while (stall && n < 50) begin
            @(posedge clk); #1;
            n++;
            chk({tag, "_nop"}, {26'd0, em_op}, {26'd0, OP_NOP});
        end
        chk({tag, "_stallcnt"}, n, 32'd33);
        @(posedge clk); #1;
        chk({tag, "_done_nop"}, {26'd0, em_op}, {26'd0, OP_NOP});
        alu({tag, "_mflo"}, OP_R, {5'd0, F_MFLO}, 32'd0, 32'd0, 32'd0, OP_R, exp_lo, 5'd9);
        alu({tag, "_mfhi"}, OP_R, {5'd0, F_MFHI}, 32'd0, 32'd0, 32'd0, OP_R, exp_hi, 5'd9);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("rst");
        rstd = 1'b1;

        alu("addi", OP_ADDI, 11'd0, 32'd5, 32'd0, 32'hFFFF_FFF9, OP_ADDI, 32'hFFFF_FFFE, 5'd3);
        alu("add",  OP_R, {5'd0, F_ADD}, 32'h7FFF_FFFF, 32'd1, 32'd0, OP_R, 32'h8000_0000, 5'd9);
        alu("sub",  OP_R, {5'd0, F_SUB}, 32'd3, 32'd5, 32'd0, OP_R, 32'hFFFF_FFFE, 5'd9);
        alu("and",  OP_R, {5'd0, F_AND}, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'd0, OP_R, 32'h00F0_1234, 5'd9);
        alu("or",   OP_R, {5'd0, F_OR},  32'hF000_0000, 32'h0000_000F, 32'd0, OP_R, 32'hF000_000F, 5'd9);
        alu("slt",  OP_R, {5'd0, F_SLT}, 32'hFFFF_FFFF, 32'd1, 32'd0, OP_R, 32'd1, 5'd9);
        alu("sltn", OP_R, {5'd0, F_SLT}, 32'd1, 32'hFFFF_FFFF, 32'd0, OP_R, 32'd0, 5'd9);
        alu("sll",  OP_R, {5'd4, F_SLL}, 32'd0, 32'd1, 32'd0, OP_R, 32'd16, 5'd9);
        alu("srl",  OP_R, {5'd31, F_SRL}, 32'd0, 32'h8000_0000, 32'd0, OP_R, 32'd1, 5'd9);
        alu("andi", OP_ANDI, 11'd0, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_8000, OP_ANDI, 32'h0000_8000, 5'd3);
        alu("ori",  OP_ORI, 11'd0, 32'h1234_0000, 32'd0, 32'hFFFF_00FF, OP_ORI, 32'h1234_00FF, 5'd3);
        alu("lw",   OP_LW, 11'd0, 32'd100, 32'd0, 32'hFFFF_FFFC, OP_LW, 32'd96, 5'd3);
        alu("sw",   OP_SW, 11'd0, 32'd100, 32'h0000_DEAD, 32'd8, OP_SW, 32'd108, 5'd0);
        chk("sw_sdata", em_sdata, 32'h0000_DEAD);

        alu("beq_t", OP_BEQ, 11'd0, 32'd9, 32'd9, 32'h20, OP_BEQ, 32'd0, 5'd0);
        chk("beq_t_taken", {31'd0, br_taken}, 32'd1);
        chk("beq_t_target", br_target, 32'h120);
        alu("beq_n", OP_BEQ, 11'd0, 32'd9, 32'd8, 32'h20, OP_BEQ, 32'd0, 5'd0);
        chk("beq_n_taken", {31'd0, br_taken}, 32'd0);

        alu("badop",   6'h3F, 11'd0, 32'd1, 32'd2, 32'd3, OP_NOP, 32'd0, 5'd0);
        alu("badfunc", OP_R, {5'd0, 6'd63}, 32'd1, 32'd2, 32'd0, OP_NOP, 32'd0, 5'd0);

        run_md("mult",  F_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 32'hFFFF_FFFF);
        run_md("multu", F_MULTU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 32'd1);
        run_md("divu",  F_DIVU, 32'd100, 32'd7, 32'd14, 32'd2);
        run_md("div",   F_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_md("divz",  F_DIVU, 32'd100, 32'd0, 32'hFFFF_FFFF, 32'd100);

        // abort a multu in the middle of BUSY
        set_in(OP_R, {5'd0, F_MULTU}, 32'd5, 32'd6, 32'd0);
        @(posedge clk); #1;
        repeat (10) @(posedge clk);
        #1;
        chk("abort_busy_stall", {31'd0, stall}, 32'd1);
        rstd = 1'b0;
        set_in(OP_NOP, 11'd0, 32'd0, 32'd0, 32'd0);
        #1;
        chk_reset_vals("abort");
        @(posedge clk); #1;
        rstd = 1'b1;
        alu("abort_mflo", OP_R, {5'd0, F_MFLO}, 32'd0, 32'd0, 32'd0, OP_R, 32'd0, 5'd9);
        alu("abort_mfhi", OP_R, {5'd0, F_MFHI}, 32'd0, 32'd0, 32'd0, OP_R, 32'd0, 5'd9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 Parameter: none; all widths fixed; opcode/funct constants come from the shared package.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rstd  input  1  reset, asynchronous, active-low.
REQ-004 pc_in  input  32  PC+4 of the instruction, from decode/execute register.
REQ-005 op_in  input  6  opcode; 6'b110111 = NOP.
REQ-006 rt_in, rd_in  input  5 each  destination register candidates.
REQ-007 aux_in  input  11  {shamt[10:6], funct[5:0]} for R-type.
REQ-008 imm_dpl_in  input  32  sign-extended immediate or pre-scaled branch displacement.
REQ-009 os_in, ot_in  input  32 each  source operands.
REQ-010 stall  output  1  combinational; high = upstream register must hold its contents.
REQ-011 em_op, em_wreg, em_result, em_sdata  output  6/5/32/32  registered EX/MEM fields.
REQ-012 br_taken, br_target  output  1/32  registered branch resolution.

Function
REQ-013 ALU ops (op 0, by funct): add 32 / sub 34 -> os+/-ot, mod 2^32, no overflow trap; and 36; or 37; slt 42 -> signed compare, 1 or 0; sll 0 -> ot<<shamt; srl 2 -> ot>>shamt, logical.
REQ-014 I-type: addi 1 -> os+imm; andi 4 / ori 5 -> os op {16'b0, imm[15:0]}; lw 16 / sw 24 -> address os+imm; em_sdata = ot_in.
REQ-015 beq 32: br_taken = (os==ot); br_target = pc_in+imm_dpl; em_wreg = 0.
REQ-016 em_wreg = rd_in for op 0, rt_in for op 1/4/5/16, 0 otherwise; unknown op or funct -> NOP to EX/MEM.
REQ-017 Single-cycle ops: result on em_* one clock after presentation (latency 1).
REQ-018 mult 24, multu 25, div 26, divu 27: iterative unit, FSM states IDLE, BUSY, DONE.
REQ-019 IDLE + mul/div at input -> stall=1 same cycle; operands latched, count=32, go BUSY.
REQ-020 BUSY: one shift-add / restoring-subtract step per cycle; stall=1; count decrements; count reaches 0 -> DONE.
REQ-021 DONE: stall=0; HI/LO written on this edge; em_op = NOP; next state IDLE; total 33 stall cycles per op.
REQ-022 Signed forms: operate on magnitudes, then negate product / quotient / remainder; remainder takes dividend sign.
REQ-023 Divide by zero: LO = 32'hFFFFFFFF, HI = dividend; no exception.
REQ-024 mfhi 16 / mflo 18 -> em_result = HI / LO; value written in DONE is visible to a mfhi/mflo in the next cycle.
REQ-025 While stall=1, EX/MEM receives NOP (em_op=6'b110111, em_wreg=0, br_taken=0); the held input is ignored except by the FSM.

Reset
REQ-026 rstd low: em_op=6'b110111; em_wreg=0; em_result=0; em_sdata=0; br_taken=0; br_target=0; HI=LO=0; FSM=IDLE; count=0; stall follows REQ-019 combinationally.
REQ-027 Reset during BUSY/DONE aborts the operation; HI/LO are not updated.

Structure
REQ-028 Shared package: opcode and funct localparams, NOP encoding 6'b110111, FSM state encoding.
REQ-029 One sub-module: muldiv_unit (FSM, HI/LO, iterative datapath, busy/done); ALU and EX/MEM register in ex_stage.

Verification
REQ-030 addi os=5, imm=-7 -> next cycle em_result=32'hFFFFFFFE, em_wreg=rt_in, stall=0.
REQ-031 mult os=-3, ot=7 -> stall high 33 cycles; then HI=32'hFFFFFFFF, LO=32'hFFFFFFEB; mflo right after -> em_result=32'hFFFFFFEB.
REQ-032 divu os=100, ot=7 -> LO=14, HI=2; div os=-7, ot=2 -> LO=-3, HI=-1; divu by 0 -> LO=32'hFFFFFFFF, HI=100.
REQ-033 beq os=ot=9, pc_in=32'h100, imm=32'h20 -> br_taken=1, br_target=32'h120; os!=ot -> br_taken=0.
REQ-034 rstd low at BUSY cycle 10 of a multu -> all outputs at reset values, stall=0 with NOP input, HI/LO stay 0.
